// File: rtl/clock_mode_ctrl.sv
// Mode and alarm sequencer for the digital alarm clock.
// Generates the time/alarm counter enables, the display select and the buzzer drive.
module clock_mode_ctrl #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       min_adv,
  input  logic       hrs_adv,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic       sec_wrap,
  input  logic       min_wrap,
  input  logic       alarm_match,
  output logic       sec_en,
  output logic       min_en,
  output logic       hrs_en,
  output logic       sec_clr,
  output logic       amin_en,
  output logic       ahrs_en,
  output logic       disp_alarm,
  output logic [1:0] mode,
  output logic       buzz
);

  localparam int unsigned SnoozeTicks = SNOOZE_MIN * 60;
  localparam int unsigned RingW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int unsigned SnzW  = (SnoozeTicks > 0) ? $clog2(SnoozeTicks + 1) : 1;
  localparam logic [RingW-1:0] RingLast = RingW'(RING_SECS - 1);
  localparam logic [SnzW-1:0]  SnzLoad  = SnzW'(SnoozeTicks);
  localparam logic [SnzW-1:0]  SnzOne   = SnzW'(1);

  typedef enum logic [1:0] {
    ModeRun      = 2'd0,
    ModeSetTime  = 2'd1,
    ModeSetAlarm = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    AlmIdle   = 2'd0,
    AlmRing   = 2'd1,
    AlmSnooze = 2'd2
  } alm_e;

  mode_e            mode_q, mode_d;
  alm_e             alm_q, alm_d;
  logic [RingW-1:0] ring_q, ring_d;
  logic [SnzW-1:0]  snz_q, snz_d;
  logic             buzz_q, buzz_d;
  logic             sec_clr_q, sec_clr_d;
  logic             btn_prev_q, snz_prev_q, match_prev_q;
  logic             btn_rise, snz_rise, match_rise, enter_set;

  assign btn_rise   = mode_btn & ~btn_prev_q;
  assign snz_rise   = snooze & ~snz_prev_q;
  assign match_rise = alarm_match & ~match_prev_q;

  always_comb begin
    mode_d = mode_q;
    if (btn_rise) begin
      case (mode_q)
        ModeSetTime:  mode_d = ModeSetAlarm;
        ModeSetAlarm: mode_d = ModeRun;
        default:      mode_d = ModeSetTime;
      endcase
    end
    enter_set = (mode_d == ModeSetTime) && (mode_q != ModeSetTime);
    sec_clr_d = enter_set;
  end

  // Disarm and entry into time setting both override every ring/snooze transition.
  always_comb begin
    alm_d  = alm_q;
    ring_d = ring_q;
    snz_d  = snz_q;
    if (!alarm_on || enter_set) begin
      alm_d  = AlmIdle;
      ring_d = '0;
      snz_d  = '0;
    end else begin
      case (alm_q)
        AlmIdle: begin
          if (match_rise && (mode_q != ModeSetTime)) begin
            alm_d  = AlmRing;
            ring_d = '0;
          end
        end
        AlmRing: begin
          if (snz_rise) begin
            alm_d = AlmSnooze;
            snz_d = SnzLoad;
          end else if (tick) begin
            if (ring_q >= RingLast) alm_d = AlmIdle;
            else                    ring_d = ring_q + 1'b1;
          end
        end
        AlmSnooze: begin
          if (tick) begin
            if (snz_q <= SnzOne) begin
              alm_d  = AlmRing;
              ring_d = '0;
            end else begin
              snz_d = snz_q - 1'b1;
            end
          end
        end
        default: alm_d = AlmIdle;
      endcase
    end
    buzz_d = (alm_d == AlmRing);
  end

  // Encoding 3 is never reached and decodes as run.
  always_comb begin
    sec_en     = tick;
    min_en     = tick & sec_wrap;
    hrs_en     = tick & sec_wrap & min_wrap;
    amin_en    = 1'b0;
    ahrs_en    = 1'b0;
    disp_alarm = 1'b0;
    case (mode_q)
      ModeSetTime: begin
        sec_en = 1'b0;
        min_en = tick & min_adv;
        hrs_en = tick & hrs_adv;
      end
      ModeSetAlarm: begin
        amin_en    = tick & min_adv;
        ahrs_en    = tick & hrs_adv;
        disp_alarm = 1'b1;
      end
      default: ;
    endcase
  end

  // Edge-detect history resets high so levels held through reset produce no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q       <= ModeRun;
      alm_q        <= AlmIdle;
      ring_q       <= '0;
      snz_q        <= '0;
      buzz_q       <= 1'b0;
      sec_clr_q    <= 1'b0;
      btn_prev_q   <= 1'b1;
      snz_prev_q   <= 1'b1;
      match_prev_q <= 1'b1;
    end else begin
      mode_q       <= mode_d;
      alm_q        <= alm_d;
      ring_q       <= ring_d;
      snz_q        <= snz_d;
      buzz_q       <= buzz_d;
      sec_clr_q    <= sec_clr_d;
      btn_prev_q   <= mode_btn;
      snz_prev_q   <= snooze;
      match_prev_q <= alarm_match;
    end
  end

  assign mode    = mode_q;
  assign buzz    = buzz_q;
  assign sec_clr = sec_clr_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with a one-minute snooze.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, mode_btn, min_adv, hrs_adv, alarm_on, snooze;
  logic       sec_wrap, min_wrap, alarm_match;
  logic       sec_en, min_en, hrs_en, sec_clr, amin_en, ahrs_en, disp_alarm, buzz;
  logic [1:0] mode;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .RING_SECS (60),
    .SNOOZE_MIN(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .mode_btn   (mode_btn),
    .min_adv    (min_adv),
    .hrs_adv    (hrs_adv),
    .alarm_on   (alarm_on),
    .snooze     (snooze),
    .sec_wrap   (sec_wrap),
    .min_wrap   (min_wrap),
    .alarm_match(alarm_match),
    .sec_en     (sec_en),
    .min_en     (min_en),
    .hrs_en     (hrs_en),
    .sec_clr    (sec_clr),
    .amin_en    (amin_en),
    .ahrs_en    (ahrs_en),
    .disp_alarm (disp_alarm),
    .mode       (mode),
    .buzz       (buzz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  task automatic press();
    mode_btn = 1'b1;
    clk1();
    mode_btn = 1'b0;
    clk1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; mode_btn = 1'b1; min_adv = 1'b0; hrs_adv = 1'b0;
    alarm_on = 1'b1; snooze = 1'b0; sec_wrap = 1'b0; min_wrap = 1'b0; alarm_match = 1'b1;
    repeat (3) clk1();
    chk("rst_mode", mode, 2'd0);
    chk("rst_buzz", buzz, 1'b0);
    chk("rst_secclr", sec_clr, 1'b0);

    // Release with button and match held high: no edge, no ring.
    rst = 1'b1;
    clk1();
    chk("rel_mode", mode, 2'd0);
    clk1();
    chk("rel_buzz", buzz, 1'b0);

    mode_btn = 1'b0;
    clk1();
    mode_btn = 1'b1;
    chk("press_pre_mode", mode, 2'd0);
    clk1();
    chk("press_mode1", mode, 2'd1);
    chk("secclr_pulse", sec_clr, 1'b1);
    mode_btn = 1'b0;
    clk1();
    chk("secclr_once", sec_clr, 1'b0);
    chk("settime_hold", mode, 2'd1);

    // Set time: minutes advance, no seconds, no carry.
    min_adv = 1'b1; sec_wrap = 1'b1; min_wrap = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      #1;
      if (min_en === 1'b1) cnt++;
      chk("st_sec_en", sec_en, 1'b0);
      chk("st_hrs_en", hrs_en, 1'b0);
      chk("st_amin_en", amin_en, 1'b0);
      clk1();
      tick = 1'b0;
      #1;
      chk("st_min_en_idle", min_en, 1'b0);
    end
    chk("st_min_pulses", cnt, 5);
    min_adv = 1'b0; sec_wrap = 1'b0;

    press();
    chk("mode_setalarm", mode, 2'd2);
    chk("disp_alarm_on", disp_alarm, 1'b1);
    hrs_adv = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      #1;
      if (ahrs_en === 1'b1) cnt++;
      chk("sa_sec_en", sec_en, 1'b1);
      chk("sa_amin_en", amin_en, 1'b0);
      chk("sa_hrs_en", hrs_en, 1'b0);
      clk1();
      tick = 1'b0;
      #1;
      chk("sa_ahrs_idle", ahrs_en, 1'b0);
    end
    chk("sa_ahrs_pulses", cnt, 3);
    hrs_adv = 1'b0;

    press();
    chk("mode_run", mode, 2'd0);
    chk("disp_alarm_off", disp_alarm, 1'b0);

    sec_wrap = 1'b1; min_wrap = 1'b1; tick = 1'b1;
    #1;
    chk("run_sec_en", sec_en, 1'b1);
    chk("run_min_en", min_en, 1'b1);
    chk("run_hrs_en", hrs_en, 1'b1);
    clk1();
    tick = 1'b0;
    #1;
    chk("run_idle_en", {sec_en, min_en, hrs_en}, 3'b000);
    sec_wrap = 1'b0; tick = 1'b1;
    #1;
    chk("run_nowrap_en", {sec_en, min_en, hrs_en}, 3'b100);
    clk1();
    tick = 1'b0;

    // Tick during a mode change still uses run enables.
    tick = 1'b1; mode_btn = 1'b1; min_adv = 1'b1;
    #1;
    chk("chg_sec_en", sec_en, 1'b1);
    chk("chg_min_en", min_en, 1'b0);
    clk1();
    tick = 1'b0; mode_btn = 1'b0; min_adv = 1'b0;
    chk("chg_mode", mode, 2'd1);
    clk1();
    press();
    press();
    chk("back_run", mode, 2'd0);

    // Ring with automatic timeout.
    alarm_match = 1'b0;
    clk1();
    alarm_match = 1'b1;
    chk("ring_pre", buzz, 1'b0);
    clk1();
    chk("ring_start", buzz, 1'b1);
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      do_tick();
      if (buzz !== (i < 60)) cnt++;
    end
    chk("ring_timeout_bad", cnt, 0);
    chk("ring_end", buzz, 1'b0);
    repeat (3) clk1();
    chk("no_rering", buzz, 1'b0);

    // Snooze on tick 10, then re-ring after exactly 60 ticks.
    alarm_match = 1'b0;
    clk1();
    alarm_match = 1'b1;
    clk1();
    chk("ring2_start", buzz, 1'b1);
    repeat (9) do_tick();
    snooze = 1'b1; tick = 1'b1;
    clk1();
    snooze = 1'b0; tick = 1'b0;
    chk("snooze_off", buzz, 1'b0);
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      snooze = (i == 30);
      do_tick();
      if (buzz !== (i == 60)) cnt++;
    end
    snooze = 1'b0;
    chk("snooze_len_bad", cnt, 0);
    chk("rering", buzz, 1'b1);
    repeat (2) do_tick();
    alarm_on = 1'b0;
    clk1();
    chk("disarm_buzz", buzz, 1'b0);
    alarm_on = 1'b1;
    cnt = 0;
    for (int i = 0; i < 62; i++) begin
      do_tick();
      if (buzz !== 1'b0) cnt++;
    end
    chk("disarm_idle", cnt, 0);

    // In set-alarm: snooze rise coincides with 60th tick, snooze must win.
    press();
    press();
    chk("sa2_mode", mode, 2'd2);
    alarm_match = 1'b0;
    clk1();
    alarm_match = 1'b1;
    clk1();
    chk("ring3_start", buzz, 1'b1);
    repeat (59) do_tick();
    chk("ring3_59", buzz, 1'b1);
    snooze = 1'b1; tick = 1'b1;
    clk1();
    snooze = 1'b0; tick = 1'b0;
    chk("tie_buzz", buzz, 1'b0);
    repeat (59) do_tick();
    chk("tie_59", buzz, 1'b0);
    do_tick();
    chk("tie_snoozed", buzz, 1'b1);

    rst = 1'b0;
    clk1();
    chk("midring_rst_buzz", buzz, 1'b0);
    chk("midring_rst_mode", mode, 2'd0);
    rst = 1'b1;
    clk1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode and alarm sequencer for the Lab 2 digital alarm clock. It replaces the loose enable glue around the seconds, minutes and hours counters (`ct_mod_N`) and the alarm minute/hour registers with one synchronous controller. It is a three-mode FSM (run, set-time, set-alarm) that generates every counter enable and the display select. A second FSM sequences the buzzer through ring, snooze and auto-timeout. Everything runs on one system clock; the 1 Hz `Pulse` enters as a one-cycle `tick` enable.

## Interface
Parameters:
- RING_SECS, 60: ticks the buzzer sounds before automatic stop.
- SNOOZE_MIN, 9: snooze length in minutes; the snooze timer loads SNOOZE_MIN*60 ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle pulse, once per second.
- mode_btn  in  1  level; its rising edge advances the mode.
- min_adv  in  1  level; advance minutes while set.
- hrs_adv  in  1  level; advance hours while set.
- alarm_on  in  1  level; alarm armed.
- snooze  in  1  level; its rising edge snoozes.
- sec_wrap  in  1  seconds counter currently at 59.
- min_wrap  in  1  minutes counter currently at 59.
- alarm_match  in  1  time hh:mm equals alarm hh:mm (from the comparator).
- sec_en, min_en, hrs_en  out  1 each  time-counter enables.
- sec_clr  out  1  synchronous clear to the seconds counter.
- amin_en, ahrs_en  out  1 each  alarm-register enables.
- disp_alarm  out  1  display muxes select alarm hh:mm.
- mode  out  2  0 RUN, 1 SET_TIME, 2 SET_ALARM.
- buzz  out  1  buzzer drive.

## Operation
Edge detection:
- Registered previous values exist for mode_btn, snooze and alarm_match.
- rise = input & ~prev.

Mode FSM (encoding 3 is unreachable and decodes as RUN):
- RUN goes to SET_TIME on a mode_btn rise.
- SET_TIME goes to SET_ALARM on a mode_btn rise.
- SET_ALARM goes to RUN on a mode_btn rise.

Enables per mode (combinational from the registered mode):
- RUN and SET_ALARM:
  - sec_en = tick.
  - min_en = tick & sec_wrap.
  - hrs_en = tick & sec_wrap & min_wrap.
- SET_TIME:
  - sec_en = 0.
  - min_en = tick & min_adv.
  - hrs_en = tick & hrs_adv.
  - There is no minute-to-hour carry.
- SET_ALARM only:
  - amin_en = tick & min_adv.
  - ahrs_en = tick & hrs_adv.
  - amin_en and ahrs_en are 0 in every other mode.
- sec_clr is a registered one-cycle pulse in the first cycle mode==SET_TIME, i.e. on entry.
- disp_alarm = (mode==SET_ALARM).

Alarm FSM:
- IDLE goes to RING when alarm_on & rise(alarm_match) & mode!=SET_TIME.
  - On entry, the ring counter loads 0.
- RING:
  - Each tick increments the ring counter.
  - When the counter reaches RING_SECS-1 and a tick arrives, go to IDLE.
  - A snooze rise goes to SNOOZE; the snooze counter loads SNOOZE_MIN*60.
- SNOOZE:
  - Each tick decrements the snooze counter.
  - A tick with the counter at 1 goes to RING; the ring counter loads 0.
  - snooze rises are ignored.
- In any state, alarm_on==0 forces IDLE and clears both counters. This has priority over all other transitions.
- Entering SET_TIME from RING or SNOOZE forces IDLE.
- buzz is registered and equals 1 exactly while the alarm FSM is in RING.

Arithmetic and width rules:
- Ring counter width is $clog2(RING_SECS).
- Snooze counter width is $clog2(SNOOZE_MIN*60+1).
- Both counters are unsigned and never wrap. Counts saturate at their bounds and the bound triggers the transition.

## Timing
- Reset values (rst==0 at a clk edge):
  - mode = RUN; alarm FSM = IDLE; both counters = 0.
  - buzz = 0; sec_clr = 0.
  - The prev registers for mode_btn, snooze and alarm_match reset to 1, so inputs held through reset produce no edge and a standing match does not ring.
- Reset mid-ring drops buzz the next cycle.
- Mode change: visible one cycle after the cycle in which the rising edge is sampled.
- A tick in the same cycle as a mode change uses the old mode's enables.
- Counter enables are combinational; they are high only in tick cycles, for one cycle each.
- Buzz latency:
  - buzz rises one cycle after the cycle where the alarm_match rise is sampled.
  - buzz falls one cycle after the terminating tick, the snooze rise, or alarm_on falling.
- Simultaneous events:
  - Snooze rise and ring timeout in the same cycle: snooze wins.
  - alarm_on low and any other event: IDLE wins.
  - A match rise during SNOOZE or RING is ignored.

## Test plan
- Reset with mode_btn held at 1, then release and press once: mode 0→1 one cycle after the press is sampled; sec_clr pulses exactly once; no transition occurs at reset release.
- RUN with sec_wrap=min_wrap=1 and one tick: sec_en, min_en and hrs_en are all 1 in that cycle only. With sec_wrap=0, only sec_en is 1.
- SET_TIME with min_adv=1 held for 5 ticks: min_en pulses 5 times; sec_en stays 0 and hrs_en stays 0 even with min_wrap=1. Then SET_ALARM with hrs_adv held for 3 ticks: ahrs_en pulses 3 times and disp_alarm=1.
- alarm_on=1, alarm_match rises: buzz=1 the next cycle. With no input for 60 ticks, buzz=0 after the 60th tick. Holding match high afterward does not re-ring.
- Ringing, snooze rise on tick 10 with SNOOZE_MIN=1: buzz=0 the next cycle, then buzz=1 again after exactly 60 ticks. Dropping alarm_on during the second ring gives buzz=0 the next cycle and FSM IDLE.
- Ringing with a snooze rise and the 60th tick in the same cycle: the FSM enters SNOOZE, not IDLE. rst=0 while ringing gives buzz=0 and mode=RUN the next cycle.
